// File: rtl/mdu_iterative_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM state encoding and the iteration count.
package mdu_iterative_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Issue/result bundle between the control unit and the multiply/divide unit.
interface mdu_iterative_if #(parameter int WIDTH = 32);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor if it fits.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_shift;
  logic             w_fits;

  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_fits  = (w_shift >= {2'b00, i_dvsr});
    if (w_fits) begin
      o_rem = (WIDTH+1)'(w_shift - {2'b00, i_dvsr});
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle MIPS32 multiply/divide unit owning HI/LO. Operands are iterated
// as magnitudes; the sign is restored in FIX and the result lands one edge later.
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input logic            clk,
  input logic            rst,
  mdu_iterative_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  mdu_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy, r_pend, r_done;
  logic               r_is_div, r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_opb, r_res_hi, r_res_lo, r_hi, r_lo;

  logic               w_accept, w_load, w_div0, w_step, w_fix;
  logic               w_op_mul, w_op_div, w_signed;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum, w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt, w_fix_hi, w_fix_lo;
  logic [2*WIDTH-1:0] w_prod;

  // busy lags the FSM by one cycle, so a start is only taken once both have
  // settled and no result write is still queued.
  always_comb begin
    w_op_mul = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
    w_op_div = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
    w_signed = op_is_signed(bus.op);
    w_div0   = w_op_div && (bus.b == '0);
    w_accept = bus.start && (r_state == ST_IDLE) && !r_busy && !r_pend;
    w_load   = w_accept && (w_op_mul || (w_op_div && !w_div0));
    w_mag_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_mag_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      ST_IDLE: if (w_load) w_state_nxt = ST_CALC;
      ST_CALC: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .i_rem  (r_rem),
    .i_quo  (r_acc[WIDTH-1:0]),
    .i_dvsr (r_opb),
    .o_rem  (w_rem_nxt),
    .o_quo  (w_quo_nxt)
  );

  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_fix_hi = r_is_div ? (r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0])
                        : w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = r_is_div ? (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0])
                        : w_prod[WIDTH-1:0];
  end

  // NOTE: iteration and staging registers carry no reset; they are always
  // loaded before use, and only control state and HI/LO need a defined value.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_is_div <= w_op_div;
      r_neg_q  <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_neg_r  <= w_signed && bus.a[WIDTH-1];
      r_opb    <= w_mag_b;
      r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
      r_rem    <= '0;
    end else if (w_step) begin
      if (r_is_div) begin
        r_rem            <= w_rem_nxt;
        r_acc[WIDTH-1:0] <= w_quo_nxt;
      end else begin
        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
      end
    end
    if (w_fix) begin
      r_res_hi <= w_fix_hi;
      r_res_lo <= w_fix_lo;
    end else if (w_accept && w_div0) begin
      r_res_hi <= bus.a;
      r_res_lo <= '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_pend <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= (r_state != ST_IDLE);
      r_pend <= w_fix || (w_accept && w_div0);
      r_done <= 1'b0;
      if (w_load)      r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + CNT_W'(1);
      if (r_pend) begin
        r_hi   <= r_res_hi;
        r_lo   <= r_res_lo;
        r_done <= 1'b1;
      end else if (w_accept && (bus.op == MDU_MTHI)) begin
        r_hi   <= bus.a;
        r_done <= 1'b1;
      end else if (w_accept && (bus.op == MDU_MTLO)) begin
        r_lo   <= bus.a;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: expected HI/LO and completion cycle are
// queued at issue and compared whenever done pulses.
module tb_mdu_iterative;
  import mdu_iterative_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_iterative_if #(.WIDTH(32)) bus();

  mdu_iterative #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb_ = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MDU_MULT:  return sa * sb_;
      MDU_MULTU: return ua * ub;
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_hi"}, bus.hi, e.hi);
        check({e.tag, "_lo"}, bus.lo, e.lo);
        check({e.tag, "_lat"}, cyc, e.exp_cyc);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge where done is seen
  // (or one later when pulse_chk is set).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int exp_busy, input bit inject, input bit pulse_chk);
    exp_t e;
    logic [31:0] ph, pl;
    int nb, lat;
    bit held, seen;
    if (op == MDU_MTHI || op == MDU_MTLO) lat = 0;
    else if ((op == MDU_DIV || op == MDU_DIVU) && b == 0) lat = 1;
    else lat = 34;
    ph = m_hi;
    pl = m_lo;
    m_hi = eh;
    m_lo = el;
    e.tag = tag; e.hi = eh; e.lo = el; e.exp_cyc = cyc + 1 + lat;
    sb.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    nb = 0; held = 1'b1; seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) nb++;
      if (bus.hi !== ph || bus.lo !== pl) held = 1'b0;
      if (inject && k == 10) begin
        bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd9; bus.b = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_cycles"}, nb, exp_busy);
    check({tag, "_hold"}, held, 1);
    if (pulse_chk) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, bus.done, 0);
    end
  endtask

  task automatic run_model(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit inject);
    logic [63:0] r;
    int eb;
    r = model(op, a, b);
    eb = ((op == MDU_DIV || op == MDU_DIVU) && b == 0) ? 0 : 33;
    run_op(tag, op, a, b, r[63:32], r[31:0], eb, inject, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op("mult_m3x5",   MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 0, 1);
    run_op("multu_max",   MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0, 1);
    run_op("div_m7d2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0, 1);
    run_op("divu_100d7",  MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33, 0, 0);
    run_op("div_ovf",     MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 0, 1);
    run_op("divu_by0",    MDU_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 0,  0, 1);
    run_op("mthi",        MDU_MTHI,  32'hCAFE_F00D, 32'd0,         32'hCAFE_F00D, m_lo,          0,  0, 0);
    run_op("mtlo",        MDU_MTLO,  32'h1234_5678, 32'd0,         32'hCAFE_F00D, 32'h1234_5678, 0,  0, 1);

    for (int i = 0; i < 4; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      run_model($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
    end

    run_model("mult_inject", MDU_MULT, 32'h0001_2345, 32'hFFFF_FF00, 1'b1);

    bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'hDEAD_BEEF; bus.b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("undef_busy", bus.busy, 0);
    check("undef_hi", bus.hi, m_hi);
    check("undef_sb_empty", sb.size(), 0);

    bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_hi", bus.hi, 0);
    check("async_rst_lo", bus.lo, 0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("multu_6x7", MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33, 0, 1);

    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit for the MIPS32 core.
- Takes the MULT/MULTU/DIV/DIVU/MTHI/MTLO work that the single-cycle ALU cannot do, and owns the HI/LO architectural registers.
- The control unit issues an operation with a start pulse and stalls on busy.
- MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is verified.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  issue strobe, sampled at rising clk
- op  in  3  operation code (mdu_defines.vh)
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- busy  out  1  operation in progress; control must stall MDU ops and MFHI/MFLO
- done  out  1  one-cycle pulse: hi/lo hold the new result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE; busy=0, done=0, hi=0, lo=0; partial results discarded.
- States: IDLE, CALC, FIX.
- IDLE, start=1 with MULT/MULTU/DIV/DIVU:
  - Latch operands as magnitudes: signed ops take the absolute value; unsigned ops use them unchanged.
  - Latch result-sign flags and clear the iteration counter.
  - Go to CALC; busy=1 from the next cycle.
- CALC: one shift-add (multiply) or one restoring-divide step per cycle.
  - 32 cycles; counter 0..31; leave to FIX after count 31.
- FIX:
  - Apply sign correction. Product is negated if the signs of a and b differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Write hi/lo. Go to IDLE with done=1 and busy=0 for that one cycle.
- Latency: start sampled at edge E0 → hi/lo/done valid after edge E0+34. busy is high after E0+1 through E0+33.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- MTHI/MTLO: write a into hi/lo at edge E0. No busy. done pulses after E0.
- Divide by zero (b=0, DIV or DIVU): no iteration. hi=a, lo=32'hFFFFFFFF. Written at edge E0+1, done pulses that cycle, busy never asserted.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. No exception.
- start while busy: ignored. Operands and op are not re-sampled, and the in-flight result is unaffected.
- start in the done cycle: accepted (state is IDLE).
- Undefined op with start=1: ignored. Stays IDLE, no done.
- hi/lo are held stable while busy and change only on the done edge.
- Internal widths:
  - Multiply accumulator is 64 bits.
  - Division remainder is 33 bits for the restoring subtract.
  - Magnitude of 0x80000000 is 0x80000000 treated unsigned.

Decomposition:
- mdu_defines.vh holds the op codes: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5.
- mdu_defines.vh also holds the state encodings and the iteration count constant (32).
- One sub-module, mdu_divstep: combinational single restoring-division step.
  - Inputs: remainder, quotient, divisor.
  - Outputs: next remainder and quotient.
  - It is the only non-trivial arithmetic, is reusable, and can be unit-tested exhaustively at reduced width.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 33 cycles; done one cycle.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 → lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → done one cycle after start, hi=0x1234, lo=0xFFFFFFFF, busy stays 0.
- MTHI a=0xCAFEF00D then MTLO a=0x12345678 on consecutive cycles → hi/lo updated; no busy.
- MULT in progress: re-pulse start with DIVU 9/3 at cycle 10 → ignored; original product delivered.
- Assert rst=0 at cycle 15 → busy=0, hi=lo=0 immediately (asynchronous).
- Next MULTU 6*7 after reset → lo=42, hi=0.
